// File: rtl/qsa_pkg.sv
// qsa_pkg: FSM state encoding and width helpers shared by the question set allocator.
package qsa_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, FILL, STREAM, DONE} state_e;

    function automatic int w_idx(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int w_cnt(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/qsa_argmin.sv
// qsa_argmin: picks the non-excluded question code with the lowest count,
// breaking ties by scanning cyclically upward from base_i.
module qsa_argmin #(
    parameter int N_Q = 3,
    parameter int CW  = 3,
    parameter int QW  = 2
) (
    input  logic [N_Q-1:0][CW-1:0] cnt_i,
    input  logic [N_Q-1:0]         excl_i,
    input  logic [QW-1:0]          base_i,
    output logic [QW-1:0]          sel_o
);

    int          idx;
    logic        found;
    logic [CW-1:0] best;

    // strict less-than keeps the earliest candidate in scan order on ties
    always_comb begin
        sel_o = '0;
        found = 1'b0;
        best  = '0;
        idx   = 0;
        for (int k = 0; k < N_Q; k++) begin
            idx = ((base_i == '0) ? 0 : int'(base_i) - 1) + k;
            idx = (idx >= N_Q) ? idx - N_Q : idx;
            if (!excl_i[idx] && (!found || cnt_i[idx] < best)) begin
                found = 1'b1;
                best  = cnt_i[idx];
                sel_o = QW'(idx + 1);
            end
        end
    end

endmodule

// File: rtl/question_set_allocator.sv
// question_set_allocator: fills a students x slots table of question codes
// column by column with balanced counts, then streams it out row-major.
module question_set_allocator
    import qsa_pkg::*;
#(
    parameter int N_STUDENTS  = 5,
    parameter int N_QUESTIONS = 3,
    parameter int N_SLOTS     = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [w_cnt(N_QUESTIONS)-1:0]     tie_base,
    output logic                              busy,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [w_idx(N_STUDENTS)-1:0]      out_student,
    output logic [w_idx(N_SLOTS)-1:0]         out_slot,
    output logic [w_cnt(N_QUESTIONS)-1:0]     out_question,
    output logic                              done
);

    localparam int SW = w_idx(N_STUDENTS);
    localparam int KW = w_idx(N_SLOTS);
    localparam int QW = w_cnt(N_QUESTIONS);
    localparam int CW = w_cnt(N_STUDENTS);

    if (N_SLOTS < 1 || N_SLOTS > N_QUESTIONS) begin : g_bad_slots
        $error("N_SLOTS must lie in 1..N_QUESTIONS");
    end

    state_e                         state_q;
    logic [QW-1:0]                  tb_q;
    logic [SW-1:0]                  r_q;
    logic [KW-1:0]                  c_q;
    logic [N_QUESTIONS-1:0][CW-1:0] cnt_q;
    logic [QW-1:0]                  tbl_q [N_STUDENTS][N_SLOTS];
    logic [N_QUESTIONS-1:0]         excl;
    logic [QW-1:0]                  sel;

    // codes already placed earlier in the current row are not candidates
    always_comb begin
        excl = '0;
        for (int j = 0; j < N_SLOTS; j++)
            for (int q = 1; q <= N_QUESTIONS; q++)
                if (j < int'(c_q) && int'(tbl_q[r_q][j]) == q) excl[q-1] = 1'b1;
    end

    qsa_argmin #(.N_Q(N_QUESTIONS), .CW(CW), .QW(QW)) u_argmin (
        .cnt_i  (cnt_q),
        .excl_i (excl),
        .base_i (tb_q),
        .sel_o  (sel)
    );

    assign busy         = state_q != IDLE;
    assign out_valid    = state_q == STREAM;
    assign done         = state_q == DONE;
    assign out_student  = out_valid ? r_q : '0;
    assign out_slot     = out_valid ? c_q : '0;
    assign out_question = out_valid ? tbl_q[r_q][c_q] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tb_q    <= QW'(1);
            r_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < N_STUDENTS; i++)
                for (int j = 0; j < N_SLOTS; j++) tbl_q[i][j] <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    tb_q    <= (tie_base == '0 || int'(tie_base) > N_QUESTIONS) ? QW'(1) : tie_base;
                    state_q <= CLEAR;
                end
                CLEAR: begin
                    r_q     <= '0;
                    c_q     <= '0;
                    cnt_q   <= '0;
                    state_q <= FILL;
                    for (int i = 0; i < N_STUDENTS; i++)
                        for (int j = 0; j < N_SLOTS; j++) tbl_q[i][j] <= '0;
                end
                FILL: begin
                    tbl_q[r_q][c_q] <= sel;
                    if (int'(r_q) == N_STUDENTS - 1) begin
                        // column complete: next column starts from zero counts
                        cnt_q   <= '0;
                        r_q     <= '0;
                        c_q     <= (int'(c_q) == N_SLOTS - 1) ? '0 : c_q + 1'b1;
                        state_q <= (int'(c_q) == N_SLOTS - 1) ? STREAM : FILL;
                    end else begin
                        r_q <= r_q + 1'b1;
                        for (int q = 0; q < N_QUESTIONS; q++)
                            if (int'(sel) == q + 1 && cnt_q[q] < CW'(N_STUDENTS)) cnt_q[q] <= cnt_q[q] + 1'b1;
                    end
                end
                STREAM: if (out_ready) begin
                    if (int'(c_q) == N_SLOTS - 1) begin
                        c_q     <= '0;
                        r_q     <= (int'(r_q) == N_STUDENTS - 1) ? '0 : r_q + 1'b1;
                        state_q <= (int'(r_q) == N_STUDENTS - 1) ? DONE : STREAM;
                    end else begin
                        c_q <= c_q + 1'b1;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_question_set_allocator.sv
// tb_question_set_allocator: randomized scoreboard bench with a high-level allocation model.
module tb_question_set_allocator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       out_ready = 1'b1;
    logic [1:0] tie_base = 2'd1;
    logic       busy, out_valid, done;
    logic [2:0] out_student;
    logic [1:0] out_slot;
    logic [1:0] out_question;

    logic       start_b = 1'b0;
    logic       ready_b = 1'b1;
    logic [2:0] tb_b = 3'd1;
    logic       busy_b, valid_b, done_b;
    logic [2:0] stud_b;
    logic [1:0] slot_b;
    logic [2:0] ques_b;

    int checks = 0;
    int errors = 0;
    int done_a = 0;
    int exp_a[$];
    int exp_b[$];
    int got_a[5][3];
    int got_b[7][4];
    int ref1[5][3] = '{'{1, 2, 3}, '{2, 1, 3}, '{3, 1, 2}, '{1, 3, 2}, '{2, 3, 1}};
    int col0_b2[5] = '{2, 3, 1, 2, 3};

    question_set_allocator dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tie_base(tie_base),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_student(out_student), .out_slot(out_slot), .out_question(out_question),
        .done(done)
    );

    question_set_allocator #(.N_STUDENTS(7), .N_QUESTIONS(4), .N_SLOTS(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .tie_base(tb_b),
        .busy(busy_b), .out_valid(valid_b), .out_ready(ready_b),
        .out_student(stud_b), .out_slot(slot_b), .out_question(ques_b),
        .done(done_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    // Reference: per column, each student takes the least-used code not yet in its row,
    // ties resolved by cyclic scan from the base; result listed row-major.
    function automatic void model(input int ns, input int nq, input int nk, input int base, output int q[$]);
        int g[8][4];
        int cnt[8];
        int best, cand;
        bit used;
        q = {};
        if (base < 1 || base > nq) base = 1;
        for (int c = 0; c < nk; c++) begin
            foreach (cnt[i]) cnt[i] = 0;
            for (int r = 0; r < ns; r++) begin
                best = -1;
                for (int k = 0; k < nq; k++) begin
                    cand = (base - 1 + k) % nq + 1;
                    used = 0;
                    for (int j = 0; j < c; j++) if (g[r][j] == cand) used = 1;
                    if (!used && (best < 0 || cnt[cand] < cnt[best])) best = cand;
                end
                g[r][c] = best;
                cnt[best]++;
            end
        end
        for (int r = 0; r < ns; r++)
            for (int c = 0; c < nk; c++) q.push_back((r << 16) | (c << 8) | g[r][c]);
    endfunction

    initial begin : mon_a
        bit pv, pr;
        int pf, f, e;
        pv = 0; pr = 0; pf = 0;
        forever begin
            @(negedge clk);
            f = (int'(out_student) << 16) | (int'(out_slot) << 8) | int'(out_question);
            if (!rst_n) begin
                pv = 0;
                continue;
            end
            if (pv && !pr) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_fields", f, pf);
            end
            if (!out_valid) chk("idle_fields_zero", f, 0);
            if (out_valid && out_ready) begin
                if (exp_a.size() == 0) chk("unexpected_transfer", f, -1);
                else begin
                    e = exp_a.pop_front();
                    chk("entry", f, e);
                end
                if (out_student < 5 && out_slot < 3) got_a[out_student][out_slot] = int'(out_question);
            end
            if (done) done_a++;
            pv = out_valid; pr = out_ready; pf = f;
        end
    end

    initial begin : mon_b
        bit pv, pr;
        int pf, f, e;
        pv = 0; pr = 0; pf = 0;
        forever begin
            @(negedge clk);
            f = (int'(stud_b) << 16) | (int'(slot_b) << 8) | int'(ques_b);
            if (!rst_n) begin
                pv = 0;
                continue;
            end
            if (pv && !pr) chk("b_stall_fields", f, pf);
            if (valid_b && ready_b) begin
                if (exp_b.size() == 0) chk("b_unexpected_transfer", f, -1);
                else begin
                    e = exp_b.pop_front();
                    chk("b_entry", f, e);
                end
                if (stud_b < 7) got_b[stud_b][slot_b] = int'(ques_b);
            end
            pv = valid_b; pr = ready_b; pf = f;
        end
    end

    task automatic go(input int base, input bit rnd, input bit hold, output int n);
        int q[$];
        int d0;
        d0 = done_a;
        tie_base = 2'(base);
        model(5, 3, 3, int'(tie_base), q);
        foreach (q[i]) exp_a.push_back(q[i]);
        start = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
            if (!hold) start = 1'b0;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end while (!done && n < 400);
        out_ready = 1'b1;
        chk("done_seen", int'(done), 1);
        @(posedge clk); #1;
        chk("done_pulses", done_a - d0, 1);
        chk("drained", exp_a.size(), 0);
    endtask

    initial begin : stim
        int n, d0, mask, n1, n2;
        int cnt[5];
        int q[$];
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_question", int'(out_question), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_no_start", int'(busy), 0);

        go(1, 0, 0, n);
        chk("done_latency", n, 32);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 3; c++) chk("rows_base1", got_a[r][c], ref1[r][c]);

        go(2, 0, 0, n);
        for (int r = 0; r < 5; r++) chk("col0_base2", got_a[r][0], col0_b2[r]);

        for (int t = 0; t < 4; t++) go(int'($urandom_range(0, 3)), 1, 0, n);

        // abort in the middle of FILL, while entry 7 is being computed
        tie_base = 2'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        chk("busy_midfill", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_done", int'(done), 0);
        exp_a.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("no_resume", int'(busy), 0);
        go(1, 0, 0, n);
        chk("done_latency_after_rst", n, 32);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 3; c++) chk("rows_after_rst", got_a[r][c], ref1[r][c]);

        // start held high: one run, one idle cycle, then exactly one restart
        go(3, 0, 1, n);
        chk("idle_gap", int'(busy), 0);
        model(5, 3, 3, 3, q);
        foreach (q[i]) exp_a.push_back(q[i]);
        d0 = done_a;
        @(posedge clk); #1;
        chk("held_restart", int'(busy), 1);
        start = 1'b0;
        n = 0;
        while (!done && n < 400) begin
            @(posedge clk); #1; n++;
        end
        chk("done_seen_held", int'(done), 1);
        @(posedge clk); #1;
        chk("done_pulses_held", done_a - d0, 1);
        chk("drained_held", exp_a.size(), 0);
        chk("idle_after_held", int'(busy), 0);

        tb_b = 3'($urandom_range(0, 7));
        model(7, 4, 4, int'(tb_b), q);
        foreach (q[i]) exp_b.push_back(q[i]);
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        n = 0;
        while (!done_b && n < 600) begin
            ready_b = 1'($urandom_range(0, 1));
            @(posedge clk); #1; n++;
        end
        ready_b = 1'b1;
        chk("b_done_seen", int'(done_b), 1);
        @(posedge clk); #1;
        chk("b_drained", exp_b.size(), 0);
        for (int r = 0; r < 7; r++) begin
            mask = 0;
            for (int c = 0; c < 4; c++) mask |= 1 << got_b[r][c];
            chk("b_row_perm", mask, 'b11110);
        end
        for (int c = 0; c < 4; c++) begin
            foreach (cnt[i]) cnt[i] = 0;
            for (int r = 0; r < 7; r++) if (got_b[r][c] >= 1 && got_b[r][c] <= 4) cnt[got_b[r][c]]++;
            n1 = 0; n2 = 0;
            for (int k = 1; k <= 4; k++) begin
                if (cnt[k] == 1) n1++;
                if (cnt[k] == 2) n2++;
            end
            chk("b_col_counts", n2 * 10 + n1, 31);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/question_set_allocator.md
QUESTION_SET_ALLOCATOR -- requirements
Module: question_set_allocator

Interface
REQ-001 Parameter N_STUDENTS, default 5, number of rows (students), >=1.
REQ-002 Parameter N_QUESTIONS, default 3, number of question codes (1..N_QUESTIONS), >=1.
REQ-003 Parameter N_SLOTS, default 3, number of answer slots (columns) per student, 1..N_QUESTIONS; any other value SHALL fail elaboration.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request a new allocation; sampled only in IDLE.
REQ-007 tie_base  input  QW  tie-break origin question code, latched on accepted start; 0 or >N_QUESTIONS is treated as 1.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 out_valid  output  1  an allocation entry is presented.
REQ-010 out_ready  input  1  consumer accepts the entry; transfer = out_valid & out_ready.
REQ-011 out_student  output  SW  row index 0..N_STUDENTS-1.
REQ-012 out_slot  output  KW  column index 0..N_SLOTS-1.
REQ-013 out_question  output  QW  assigned question code 1..N_QUESTIONS.
REQ-014 done  output  1  one-cycle pulse after the final transfer.
REQ-015 Widths: SW=max(1,$clog2(N_STUDENTS)), KW=max(1,$clog2(N_SLOTS)), QW=$clog2(N_QUESTIONS+1), count width CW=$clog2(N_STUDENTS+1).

Function
REQ-016 FSM states IDLE, CLEAR, FILL, STREAM, DONE; IDLE->CLEAR on start, CLEAR->FILL after 1 cycle, FILL->STREAM after N_STUDENTS*N_SLOTS cycles, STREAM->DONE on final transfer, DONE->IDLE after 1 cycle.
REQ-017 start while busy SHALL be ignored, with no effect on the run in progress.
REQ-018 CLEAR SHALL zero the whole table (N_STUDENTS x N_SLOTS codes) and all N_QUESTIONS column counters.
REQ-019 FILL SHALL compute exactly one entry per cycle in column-major order: (r=0,c=0),(1,0)..(N_STUDENTS-1,0),(0,1)...
REQ-020 Entry (r,c) SHALL be the code q not already present in row r columns 0..c-1 whose column-c count is minimal.
REQ-021 Among equal minimal counts, the first candidate found scanning cyclically upward from tie_base SHALL win.
REQ-022 The written entry SHALL increment its counter by 1, saturating at N_STUDENTS.
REQ-023 All counters SHALL clear in the same cycle that c advances, so the first row of each new column sees zero counts.
REQ-024 Guarantee: no code repeats within a row; per-column counts differ by at most 1 whenever the excluded set permits.
REQ-025 STREAM SHALL present entries row-major, (0,0),(0,1)..(0,N_SLOTS-1),(1,0)...; out_valid rises the cycle after the last FILL write.
REQ-026 While out_valid=1 and out_ready=0, out_student, out_slot and out_question SHALL hold stable; out_valid SHALL NOT drop before the transfer.
REQ-027 Back-to-back transfers SHALL sustain one entry per cycle while out_ready=1.
REQ-028 out_valid SHALL be 0 outside STREAM; out_student, out_slot and out_question SHALL read 0 when out_valid=0.
REQ-029 done SHALL assert exactly in the DONE cycle.
REQ-030 A start in the DONE cycle SHALL be ignored; a start is accepted from the following IDLE cycle.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, regardless of current state, including mid-FILL or a stalled STREAM.
REQ-032 rst_n low SHALL immediately force busy=0, out_valid=0, done=0, all out_* fields=0, all counters and table entries=0, and latched tie_base=1.
REQ-033 After deassertion the block SHALL idle until a new start; no partial run resumes.

Structure
REQ-034 Package qsa_pkg SHALL hold the FSM state enum and width helper functions.
REQ-035 Sub-module qsa_argmin SHALL hold the combinational selector: inputs are the counts vector, exclusion mask and tie_base; output is the selected code.
REQ-036 The table is a register array; no memory macro.

Verification
REQ-037 Defaults, tie_base=1, start pulse, out_ready=1 -> rows (1,2,3),(2,1,3),(3,1,2),(1,3,2),(2,3,1) streamed; done asserts 1+1+15+15 cycles after start is accepted.
REQ-038 Defaults, tie_base=2 -> column 0 = 2,3,1,2,3; every row holds three distinct codes.
REQ-039 out_ready toggled randomly -> out_* stable during stalls, 15 transfers, no loss or duplication, single done pulse.
REQ-040 rst_n pulsed low mid-FILL (entry 7) -> busy, out_valid and done low the same cycle; a subsequent start reproduces REQ-037 exactly.
REQ-041 N_STUDENTS=7, N_QUESTIONS=4, N_SLOTS=4 -> each row is a permutation of 1..4; each column's counts are {2,2,2,1} in some order.
REQ-042 start held high across the whole run -> exactly one run before IDLE; a new run begins on the first IDLE cycle.
